// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC processor: opcodes, ALU control codes,
// control-unit state type and status-register bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_ALU_R = 4'h1;
    localparam logic [3:0] OP_ALU_I = 4'h2;
    localparam logic [3:0] OP_BRA   = 4'h4;
    localparam logic [3:0] OP_BRR   = 4'h5;
    localparam logic [3:0] OP_BNE   = 4'h6;
    localparam logic [3:0] OP_BNR   = 4'h7;
    localparam logic [3:0] OP_LOD   = 4'h8;
    localparam logic [3:0] OP_STR   = 4'h9;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_NOP  = 2'b10;
    localparam logic [1:0] ALU_ADDR = 2'b11;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } ctrl_state_t;

    // ALU control used from EXECUTE through WRITEBACK so alu_result stays stable.
    function automatic logic [1:0] exec_alu_op(input logic [3:0] opcode);
        case (opcode)
            OP_ALU_R:       return ALU_RR;
            OP_ALU_I:       return ALU_RI;
            OP_LOD, OP_STR: return ALU_ADDR;
            default:        return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sisc_ctrl_if.sv
// Control-unit bundle: instruction fields and status in, datapath strobes out.
// master = control unit, slave = datapath.
interface sisc_ctrl_if;

    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       rf_we;
    logic       wb_sel;
    logic       rd_sel;
    logic [1:0] alu_op;
    logic       sr_load;
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic       ir_load;
    logic       mm_sel;
    logic       dm_we;
    logic       halt;

    modport master (
        input  opcode, mm, stat,
        output rf_we, wb_sel, rd_sel, alu_op, sr_load, pc_rst, pc_write,
               pc_sel, br_sel, ir_load, mm_sel, dm_we, halt
    );

    modport slave (
        output opcode, mm, stat,
        input  rf_we, wb_sel, rd_sel, alu_op, sr_load, pc_rst, pc_write,
               pc_sel, br_sel, ir_load, mm_sel, dm_we, halt
    );

endinterface

// File: rtl/sisc_br_eval.sv
// Conditional-branch evaluator: masks the status flags with the instruction's
// condition field and reports whether the branch is taken and PC-relative.
module sisc_br_eval
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       br_taken,
    output logic       br_rel
);

    logic any_set;

    assign any_set = |(mm & stat);

    always_comb begin
        br_taken = 1'b0;
        br_rel   = 1'b0;
        case (opcode)
            OP_BRA: br_taken = any_set;
            OP_BRR: begin br_taken = any_set;  br_rel = 1'b1; end
            OP_BNE: br_taken = !any_set;
            OP_BNR: begin br_taken = !any_set; br_rel = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath strobes.
module sisc_ctrl
    import sisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_f,
    sisc_ctrl_if.master bus
);

    ctrl_state_t state, next_state;
    logic        br_taken, br_rel;

    sisc_br_eval u_br_eval (
        .opcode   (bus.opcode),
        .mm       (bus.mm),
        .stat     (bus.stat),
        .br_taken (br_taken),
        .br_rel   (br_rel)
    );

    // NOTE: state is the only register, so it alone uses non-blocking
    // assignments; everything below is combinational and uses blocking ones.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= START0;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            START0:    next_state = START1;
            START1:    next_state = FETCH;
            FETCH:     next_state = DECODE;
            DECODE:    next_state = (bus.opcode == OP_HLT) ? HALT : EXECUTE;
            EXECUTE:   next_state = MEM;
            MEM:       next_state = WRITEBACK;
            WRITEBACK: next_state = FETCH;
            HALT:      next_state = HALT;
            default:   next_state = START0;
        endcase
    end

    // NOTE: every output gets its default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.rd_sel   = 1'b0;
        bus.alu_op   = ALU_NOP;
        bus.sr_load  = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.mm_sel   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.halt     = 1'b0;

        case (state)
            START0: bus.pc_rst = 1'b1;
            FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            DECODE: begin
                // Relative targets are added to the PC already bumped in FETCH.
                bus.br_sel = br_rel;
                if (br_taken) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 1'b1;
                end
            end
            EXECUTE: begin
                bus.alu_op  = exec_alu_op(bus.opcode);
                bus.sr_load = (bus.opcode == OP_ALU_R) || (bus.opcode == OP_ALU_I);
                bus.rd_sel  = (bus.opcode == OP_STR);
            end
            MEM: begin
                bus.alu_op = exec_alu_op(bus.opcode);
                if (bus.opcode == OP_LOD) begin
                    bus.mm_sel = 1'b1;
                end else if (bus.opcode == OP_STR) begin
                    bus.mm_sel = 1'b1;
                    bus.dm_we  = 1'b1;
                    bus.rd_sel = 1'b1;
                end
            end
            WRITEBACK: begin
                bus.alu_op = exec_alu_op(bus.opcode);
                if (bus.opcode == OP_ALU_R || bus.opcode == OP_ALU_I) begin
                    bus.rf_we = 1'b1;
                end else if (bus.opcode == OP_LOD) begin
                    bus.rf_we  = 1'b1;
                    bus.wb_sel = 1'b1;
                    bus.mm_sel = 1'b1;
                end
            end
            HALT:    bus.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/sisc_ctrl.md
# sisc_ctrl

Multi-cycle control unit for the SISC processor, directly upstream of the ALU. Sequences every instruction through fetch, decode, execute, memory and writeback. Drives the ALU's `alu_op` lines, the status-register load, PC/IR/register-file/data-memory strobes and datapath mux selects. Evaluates conditional branches against the 4-bit status register (C V N Z) produced from the ALU's `stat`/`stat_en`.

## Interface
Parameters: none. All encodings come from the shared package.

- `clk`  in  1  system clock; all state changes on posedge
- `rst_f`  in  1  asynchronous, active-low reset
- `opcode`  in  4  instruction bits [31:28], from IR output; stable from DECODE through WRITEBACK
- `mm`  in  4  instruction bits [27:24]; branch condition mask
- `stat`  in  4  status register contents {C,V,N,Z}
- `rf_we`  out  1  register-file write enable
- `wb_sel`  out  1  writeback source: 0 = ALU result, 1 = data memory
- `rd_sel`  out  1  1 = route Rd to register-file read port B (stores)
- `alu_op`  out  2  ALU control: 00 reg-reg, 01 reg-imm, 10 no-op/no-stat, 11 address calc (imm, no stat)
- `sr_load`  out  1  status register capture strobe; ANDed with ALU `stat_en` outside this block
- `pc_rst`  out  1  clear PC to 0
- `pc_write`  out  1  load PC
- `pc_sel`  out  1  PC source: 0 = PC+1, 1 = branch target
- `br_sel`  out  1  branch target: 0 = absolute imm, 1 = PC+imm
- `ir_load`  out  1  load instruction register
- `mm_sel`  out  1  memory address source: 0 = PC, 1 = ALU result
- `dm_we`  out  1  data-memory write enable
- `halt`  out  1  processor halted

## Operation
- Opcodes: NOOP=0, ALU_R=1, ALU_I=2, BRA=4, BRR=5, BNE=6, BNR=7, LOD=8, STR=9, HLT=15. All others execute as NOOP.
- States: START0 → START1 → FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH. DECODE with HLT → HALT. HALT is absorbing; only `rst_f` leaves it.
- Default for every output in every state is 0, except `alu_op`, which defaults to 10.
- START0: `pc_rst`=1.
- START1: all outputs at default.
- FETCH: `ir_load`=1, `pc_write`=1, `pc_sel`=0, `mm_sel`=0.
- DECODE, branch opcodes: taken = ((`mm` & `stat`) != 0) for BRA/BRR, == 0 for BNE/BNR.
  - If taken: `pc_write`=1, `pc_sel`=1.
  - `br_sel`=1 for BRR/BNR, 0 for BRA/BNE. Relative target is based on the already-incremented PC.
- EXECUTE:
  - ALU_R: `alu_op`=00, `sr_load`=1.
  - ALU_I: `alu_op`=01, `sr_load`=1.
  - LOD/STR: `alu_op`=11; STR also `rd_sel`=1.
- MEM:
  - `alu_op` holds its EXECUTE value.
  - LOD: `mm_sel`=1.
  - STR: `mm_sel`=1, `dm_we`=1, `rd_sel`=1.
- WRITEBACK:
  - `alu_op` holds its EXECUTE value.
  - ALU_R/ALU_I: `rf_we`=1, `wb_sel`=0.
  - LOD: `rf_we`=1, `wb_sel`=1, `mm_sel`=1.
- HALT: `halt`=1, all other outputs at default.

## Timing
- State register is the only storage. Outputs are combinational from state, `opcode`, `mm` and `stat` (Mealy only for DECODE branch outputs).
- Reset: `rst_f` low forces START0 immediately, regardless of current state (including mid-EXECUTE or HALT).
- Reset output values: `pc_rst`=1, `alu_op`=10, all other outputs 0.
- After `rst_f` rises: START0 for 1 cycle, START1 for 1 cycle, first FETCH on the 3rd posedge.
- Every non-HLT instruction takes exactly 5 cycles, FETCH to WRITEBACK. Branches and NOOPs are not shortened.
- ALU latches `alu_result` at the end of EXECUTE, so it is valid during MEM and WRITEBACK.
- Status register captures at the end of EXECUTE. A branch in the immediately following instruction sees the updated flags in its DECODE.
- `sr_load` is asserted only in EXECUTE, never in MEM or WRITEBACK, so the status register is written at most once per instruction.

## Structure
- Shared package `sisc_pkg` holds:
  - opcode constants;
  - `alu_op` encodings (ALU_RR, ALU_RI, ALU_NOP, ALU_ADDR);
  - state enum typedef `ctrl_state_t`;
  - status bit indices C=3, V=2, N=1, Z=0.
- Sub-module `sisc_br_eval` (combinational): inputs `opcode`, `mm`, `stat`; outputs `br_taken`, `br_rel`. Instantiated once; drives DECODE branch outputs.

## Test plan
- Hold `rst_f` low for 3 cycles, then release: `pc_rst`=1 and `alu_op`=10 during reset; on 3rd posedge after release, `ir_load`=1, `pc_write`=1, `pc_sel`=0.
- `opcode`=1: EXECUTE `alu_op`=00, `sr_load`=1; WRITEBACK `rf_we`=1, `wb_sel`=0; FETCH exactly 5 cycles after previous FETCH.
- BRA, `mm`=0001:
  - `stat`=0001 → DECODE `pc_write`=1, `pc_sel`=1, `br_sel`=0.
  - `stat`=1110 → `pc_write`=0.
- BNR, `mm`=0010, `stat`=0000 → taken, `br_sel`=1. Repeat with `stat`=0010 → not taken.
- LOD: EXECUTE `alu_op`=11, `sr_load`=0; MEM `mm_sel`=1, `dm_we`=0; WRITEBACK `rf_we`=1, `wb_sel`=1.
- STR: `rd_sel`=1 in EXECUTE and MEM; `dm_we`=1 in MEM only; `rf_we`=0 throughout.
- HLT: `halt`=1 held for 20 cycles with no strobes. Drop `rst_f` mid-EXECUTE of an ALU_R: `sr_load` falls and `pc_rst` rises before the next clock edge.
